// File: rtl/adc_wrapper.sv
// adc_wrapper: board-level top for the DE0-Nano parallel ADC capture design.
//
// Samples a 10-bit parallel ADC on GPIO_1 every CLOCK_50 cycle. Over each
// window of 2^WINDOW_LOG2 samples it tracks the minimum and maximum and latches
// them at the end of the window. LED[7:0] shows one statistic, selected by
// SW[3:2]. All other board peripherals are held idle.
//
// Ports
//   CLOCK_50            system clock, rising edge
//   reset               synchronous active-high reset
//   KEY[0]              active-low reset button (2-flop synchronized)
//   KEY[1]              active-low clear of latched statistics (synchronized)
//   SW[0]               freeze latched statistics; SW[1] unused;
//                       SW[3:2] LED mode (00 max, 01 min, 10 p2p, 11 level)
//   LED[7:0]            registered display
//   DRAM_*              SDRAM, held idle (clock forwarded, DQ released)
//   I2C_SCLK/I2C_SDAT   released
//   G_SENSOR_*          accelerometer, deselected
//   ADC_*               on-board serial ADC, deselected
//   GPIO_0/GPIO_2       released; GPIO_1 carries the parallel ADC bus and
//                       the forwarded ADC sample clock on GPIO_1[17]
//
// Build option
//   ADC_MEAN_EN         adds a per-window mean; LED mode 11 then shows the
//                       latched mean instead of the level thermometer.
module adc_wrapper #(
  parameter int WINDOW_LOG2 = 16
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [1:0]  KEY,
  input  logic [3:0]  SW,
  output logic [7:0]  LED,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic [1:0]  DRAM_DQM,
  output logic        DRAM_CKE,
  output logic        DRAM_CLK,
  output logic        DRAM_CS_N,
  output logic        DRAM_RAS_N,
  output logic        DRAM_CAS_N,
  output logic        DRAM_WE_N,
  inout  wire  [15:0] DRAM_DQ,
  inout  wire         I2C_SCLK,
  inout  wire         I2C_SDAT,
  output logic        G_SENSOR_CS_N,
  input  logic        G_SENSOR_INT,
  output logic        ADC_CS_N,
  output logic        ADC_SADDR,
  output logic        ADC_SCLK,
  input  logic        ADC_SDAT,
  inout  wire  [33:0] GPIO_0,
  input  logic [1:0]  GPIO_0_IN,
  inout  wire  [33:0] GPIO_1,
  input  logic [1:0]  GPIO_1_IN,
  inout  wire  [12:0] GPIO_2,
  input  logic [2:0]  GPIO_2_IN
);

  localparam logic [WINDOW_LOG2-1:0] WC_TERM = '1;

  // Parked peripherals
  assign DRAM_CLK      = CLOCK_50;
  assign DRAM_CKE      = 1'b1;
  assign DRAM_CS_N     = 1'b1;
  assign DRAM_RAS_N    = 1'b1;
  assign DRAM_CAS_N    = 1'b1;
  assign DRAM_WE_N     = 1'b1;
  assign DRAM_ADDR     = '0;
  assign DRAM_BA       = '0;
  assign DRAM_DQM      = 2'b11;
  assign DRAM_DQ       = {16{1'bz}};
  assign I2C_SCLK      = 1'bz;
  assign I2C_SDAT      = 1'bz;
  assign G_SENSOR_CS_N = 1'b1;
  assign ADC_CS_N      = 1'b1;
  assign ADC_SCLK      = 1'b1;
  assign ADC_SADDR     = 1'b0;
  assign GPIO_0        = {34{1'bz}};
  assign GPIO_2        = {13{1'bz}};

  // GPIO_1: only the ADC sample clock is driven; the data pins are inputs.
  assign GPIO_1[16:0]  = {17{1'bz}};
  assign GPIO_1[17]    = CLOCK_50;
  assign GPIO_1[33:18] = {16{1'bz}};

  logic unused;
  assign unused = ^{SW[1], G_SENSOR_INT, ADC_SDAT, GPIO_0_IN, GPIO_1_IN,
                    GPIO_2_IN, GPIO_0, GPIO_2, DRAM_DQ, I2C_SCLK, I2C_SDAT,
                    GPIO_1[18:0], GPIO_1[20], GPIO_1[22], GPIO_1[24],
                    GPIO_1[26], GPIO_1[28]};

  // ADC bus as routed on the board (bit order is not contiguous).
  logic [9:0] adc_d;
  assign adc_d = {GPIO_1[21], GPIO_1[23], GPIO_1[19], GPIO_1[25], GPIO_1[27],
                  GPIO_1[33], GPIO_1[29], GPIO_1[31], GPIO_1[30], GPIO_1[32]};

  // Button synchronizers. Only the external reset clears them: the KEY[0]
  // path must not be able to hold itself in reset.
  logic k0_meta, k0_sync, k1_meta, k1_sync;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      k0_meta <= 1'b1;
      k0_sync <= 1'b1;
      k1_meta <= 1'b1;
      k1_sync <= 1'b1;
    end else begin
      k0_meta <= KEY[0];
      k0_sync <= k0_meta;
      k1_meta <= KEY[1];
      k1_sync <= k1_meta;
    end
  end

  logic rst_i, clear_i, freeze, terminal;
  assign rst_i   = reset | ~k0_sync;
  assign clear_i = ~k1_sync;
  assign freeze  = SW[0];

  logic [9:0]             s1, s2;
  logic [WINDOW_LOG2-1:0] wc;
  logic [9:0]             run_max, run_min, max_nxt, min_nxt;
  logic [9:0]             latched_max, latched_min, p2p;
  logic [7:0]             therm, led_nxt;

  assign terminal = (wc == WC_TERM);

  // Running extremes including the current sample, so the terminal sample
  // lands in the window it belongs to.
  assign max_nxt = (s2 > run_max) ? s2 : run_max;
  assign min_nxt = (s2 < run_min) ? s2 : run_min;
  assign p2p     = latched_max - latched_min;

  always_comb begin
    therm = '0;
    for (int i = 0; i < 8; i++) begin
      therm[i] = (s2[9:7] > 3'(i));
    end
  end

`ifdef ADC_MEAN_EN
  logic [WINDOW_LOG2+9:0] acc, acc_nxt;
  logic [9:0]             latched_mean;

  assign acc_nxt = acc + {{WINDOW_LOG2{1'b0}}, s2};

  always_ff @(posedge CLOCK_50) begin
    if (rst_i) begin
      acc          <= '0;
      latched_mean <= '0;
    end else begin
      acc <= terminal ? '0 : acc_nxt;
      if (clear_i) begin
        latched_mean <= '0;
      end else if (terminal && !freeze) begin
        latched_mean <= acc_nxt[WINDOW_LOG2 +: 10];
      end
    end
  end
`endif

  always_comb begin
    led_nxt = latched_max[9:2];
    case (SW[3:2])
      2'b00:   led_nxt = latched_max[9:2];
      2'b01:   led_nxt = latched_min[9:2];
      2'b10:   led_nxt = p2p[9:2];
`ifdef ADC_MEAN_EN
      default: led_nxt = latched_mean[9:2];
`else
      default: led_nxt = therm;
`endif
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst_i) begin
      s1          <= '0;
      s2          <= '0;
      wc          <= '0;
      run_max     <= '0;
      run_min     <= 10'h3FF;
      latched_max <= '0;
      latched_min <= '0;
      LED         <= '0;
    end else begin
      s1  <= adc_d;
      s2  <= s1;
      wc  <= wc + 1'b1;
      LED <= led_nxt;

      // The running extremes restart every window, even while frozen.
      if (terminal) begin
        run_max <= '0;
        run_min <= 10'h3FF;
      end else begin
        run_max <= max_nxt;
        run_min <= min_nxt;
      end

      // Clear wins over a latch in the same cycle.
      if (clear_i) begin
        latched_max <= '0;
        latched_min <= '0;
      end else if (terminal && !freeze) begin
        latched_max <= max_nxt;
        latched_min <= min_nxt;
      end
    end
  end

endmodule

// File: tb/tb_adc_wrapper.sv
module tb_adc_wrapper;

  localparam int WL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  key;
  logic [3:0]  sw;
  logic [9:0]  adc_val;
  logic [7:0]  led;
  logic [12:0] dram_addr;
  logic [1:0]  dram_ba, dram_dqm;
  logic        dram_cke, dram_clk, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n;
  logic        g_sensor_cs_n, adc_cs_n, adc_saddr, adc_sclk;
  wire  [15:0] dram_dq;
  wire         i2c_sclk, i2c_sdat;
  wire  [33:0] gpio_0, gpio_1;
  wire  [12:0] gpio_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign gpio_1[21] = adc_val[9];
  assign gpio_1[23] = adc_val[8];
  assign gpio_1[19] = adc_val[7];
  assign gpio_1[25] = adc_val[6];
  assign gpio_1[27] = adc_val[5];
  assign gpio_1[33] = adc_val[4];
  assign gpio_1[29] = adc_val[3];
  assign gpio_1[31] = adc_val[2];
  assign gpio_1[30] = adc_val[1];
  assign gpio_1[32] = adc_val[0];

  adc_wrapper #(.WINDOW_LOG2(WL)) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .KEY           (key),
    .SW            (sw),
    .LED           (led),
    .DRAM_ADDR     (dram_addr),
    .DRAM_BA       (dram_ba),
    .DRAM_DQM      (dram_dqm),
    .DRAM_CKE      (dram_cke),
    .DRAM_CLK      (dram_clk),
    .DRAM_CS_N     (dram_cs_n),
    .DRAM_RAS_N    (dram_ras_n),
    .DRAM_CAS_N    (dram_cas_n),
    .DRAM_WE_N     (dram_we_n),
    .DRAM_DQ       (dram_dq),
    .I2C_SCLK      (i2c_sclk),
    .I2C_SDAT      (i2c_sdat),
    .G_SENSOR_CS_N (g_sensor_cs_n),
    .G_SENSOR_INT  (1'b0),
    .ADC_CS_N      (adc_cs_n),
    .ADC_SADDR     (adc_saddr),
    .ADC_SCLK      (adc_sclk),
    .ADC_SDAT      (1'b0),
    .GPIO_0        (gpio_0),
    .GPIO_0_IN     (2'b00),
    .GPIO_1        (gpio_1),
    .GPIO_1_IN     (2'b00),
    .GPIO_2        (gpio_2),
    .GPIO_2_IN     (3'b000)
  );

  // {CKE, CS_N, RAS_N, CAS_N, WE_N, ADDR, BA, DQM, G_CS_N, ADC_CS_N, ADC_SCLK, ADC_SADDR}
  localparam logic [25:0] PARK_EXP = {5'b11111, 13'h0000, 2'b00, 2'b11, 4'b1110};
  logic [25:0] park_act;
  assign park_act = {dram_cke, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
                     dram_addr, dram_ba, dram_dqm, g_sensor_cs_n, adc_cs_n,
                     adc_sclk, adc_saddr};

  logic [9:0] thermo_in  [4] = '{10'h3FF, 10'h180, 10'h080, 10'h37F};
  logic [7:0] thermo_exp [4] = '{8'h7F,   8'h07,   8'h01,   8'h3F};

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge just before the first post-reset edge (P0).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    key   = 2'b11;
    tick(3);
    reset = 1'b0;
  endtask

  // Called at a negedge; advances exactly one cycle.
  task automatic test_parked(input string tag);
    #1;
    checks++;
    if (dram_clk !== 1'b0) begin
      errors++;
      $display("FAIL %s dram_clk_low got=%b exp=0", tag, dram_clk);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dram_clk !== 1'b1 || park_act !== PARK_EXP) begin
      errors++;
      $display("FAIL %s parked got clk=%b vec=%h exp clk=1 vec=%h", tag, dram_clk, park_act, PARK_EXP);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; key = 2'b11; sw = 4'b0000; adc_val = 10'h000;
    tick(3);
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL reset_led got=%h exp=00", led);
    end
    test_parked("reset");
    reset = 1'b0;
    test_parked("run");
  endtask

  task automatic test_ramp();
    do_reset();
    sw = 4'b0000;
    for (int n = 0; n < 16; n++) begin
      adc_val = 10'(n + 2);
      tick(1);
    end
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL ramp_before_latch got=%h exp=00", led);
    end
    adc_val = 10'd18;
    tick(1);
    checks++;
    if (led !== 8'h03) begin
      errors++; $display("FAIL ramp_max_w1 got=%h exp=03", led);
    end
    sw = 4'b0100;
    for (int n = 17; n < 32; n++) begin
      adc_val = 10'(n + 2);
      tick(1);
    end
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL ramp_min_w1 got=%h exp=00", led);
    end
    adc_val = 10'd34;
    tick(1);
    checks++;
    if (led !== 8'h04) begin
      errors++; $display("FAIL ramp_min_w2 got=%h exp=04", led);
    end
    sw = 4'b1000;
    adc_val = 10'd35;
    tick(1);
    checks++;
    if (led !== 8'h03) begin
      errors++; $display("FAIL ramp_p2p_w2 got=%h exp=03", led);
    end
    sw = 4'b0000;
    adc_val = 10'd36;
    tick(1);
    checks++;
    if (led !== 8'h07) begin
      errors++; $display("FAIL ramp_max_w2 got=%h exp=07", led);
    end
  endtask

  // A single high sample lands exactly on the terminal cycle of window 1.
  task automatic test_terminal_sample();
    do_reset();
    sw = 4'b0000;
    adc_val = 10'h000;
    tick(13);
    adc_val = 10'h3FC;
    tick(1);
    adc_val = 10'h000;
    tick(2);
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL term_sample_early got=%h exp=00", led);
    end
    tick(1);
    checks++;
    if (led !== 8'hFF) begin
      errors++; $display("FAIL term_sample_w1 got=%h exp=ff", led);
    end
    tick(15);
    checks++;
    if (led !== 8'hFF) begin
      errors++; $display("FAIL term_sample_hold got=%h exp=ff", led);
    end
    tick(1);
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL term_sample_w2 got=%h exp=00", led);
    end
  endtask

  task automatic test_thermometer();
    logic [7:0] prev;
    do_reset();
    sw = 4'b1100;
    adc_val = 10'h000;
    tick(4);
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL thermo_zero got=%h exp=00", led);
    end
    prev = 8'h00;
    for (int i = 0; i < 4; i++) begin
      adc_val = thermo_in[i];
      tick(2);
      checks++;
      if (led !== prev) begin
        errors++; $display("FAIL thermo_latency%0d got=%h exp=%h", i, led, prev);
      end
      tick(1);
      checks++;
      if (led !== thermo_exp[i]) begin
        errors++; $display("FAIL thermo_level%0d got=%h exp=%h", i, led, thermo_exp[i]);
      end
      prev = thermo_exp[i];
    end
  endtask

  task automatic test_freeze();
    do_reset();
    sw = 4'b0000;
    adc_val = 10'h200;
    tick(17);
    checks++;
    if (led !== 8'h80) begin
      errors++; $display("FAIL freeze_initial got=%h exp=80", led);
    end
    sw = 4'b0001;
    adc_val = 10'h3FC;
    for (int w = 0; w < 3; w++) begin
      tick(16);
      checks++;
      if (led !== 8'h80) begin
        errors++; $display("FAIL freeze_hold%0d got=%h exp=80", w, led);
      end
    end
    sw = 4'b0000;
    tick(15);
    checks++;
    if (led !== 8'h80) begin
      errors++; $display("FAIL freeze_pre_release got=%h exp=80", led);
    end
    tick(1);
    checks++;
    if (led !== 8'hFF) begin
      errors++; $display("FAIL freeze_release_max got=%h exp=ff", led);
    end
    sw = 4'b0100;
    tick(1);
    checks++;
    if (led !== 8'hFF) begin
      errors++; $display("FAIL freeze_release_min got=%h exp=ff", led);
    end
    sw = 4'b1000;
    tick(1);
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL freeze_release_p2p got=%h exp=00", led);
    end
  endtask

  task automatic test_clear();
    do_reset();
    sw = 4'b0000;
    adc_val = 10'h300;
    tick(17);
    checks++;
    if (led !== 8'hC0) begin
      errors++; $display("FAIL clear_initial got=%h exp=c0", led);
    end
    tick(12);
    key = 2'b01;
    tick(1);
    key = 2'b11;
    tick(2);
    checks++;
    if (led !== 8'hC0) begin
      errors++; $display("FAIL clear_pre got=%h exp=c0", led);
    end
    tick(1);
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL clear_max got=%h exp=00", led);
    end
    sw = 4'b0100;
    tick(1);
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL clear_min got=%h exp=00", led);
    end
    tick(15);
    checks++;
    if (led !== 8'hC0) begin
      errors++; $display("FAIL clear_next_window got=%h exp=c0", led);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    sw = 4'b0000;
    adc_val = 10'h3FF;
    tick(17);
    checks++;
    if (led !== 8'hFF) begin
      errors++; $display("FAIL midrst_initial got=%h exp=ff", led);
    end
    tick(4);
    reset = 1'b1;
    tick(1);
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL midrst_led got=%h exp=00", led);
    end
    test_parked("midrst");
    reset = 1'b0;
    tick(16);
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL midrst_window_early got=%h exp=00", led);
    end
    tick(1);
    checks++;
    if (led !== 8'hFF) begin
      errors++; $display("FAIL midrst_window_full got=%h exp=ff", led);
    end
  endtask

  task automatic test_key0_reset();
    do_reset();
    sw = 4'b0000;
    adc_val = 10'h3FF;
    tick(17);
    key = 2'b10;
    tick(2);
    checks++;
    if (led !== 8'hFF) begin
      errors++; $display("FAIL key0_sync_delay got=%h exp=ff", led);
    end
    tick(1);
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("FAIL key0_reset got=%h exp=00", led);
    end
    key = 2'b11;
    tick(2);
  endtask

  initial begin
    reset = 1'b1; key = 2'b11; sw = 4'b0000; adc_val = 10'h000;
    test_reset();
    test_ramp();
    test_terminal_sample();
    test_thermometer();
    test_freeze();
    test_clear();
    test_mid_reset();
    test_key0_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
